pu_accum_queue: RTL and testbench

PU_ACCUM_QUEUE -- requirements
Module: pu_accum_queue

---
 rtl/pu_accum_queue.sv | 107 ++++++++++
 tb/tb_pu_accum_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pu_accum_queue.sv
// Signed accumulator that closes sums into a small FIFO of {sum, overflow} results.
// Popped entries appear on registered outputs one cycle after signal_oe.
module pu_accum_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1,
    parameter int DEPTH      = 4,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic                  signal_commit,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  buf_full,
    output logic                  buf_empty,
    output logic                  lost
);
    localparam int AW  = $clog2(DEPTH);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] acc, acc_nxt, op, sum;
    logic                  ovf, ovf_nxt, neg_ovf, add_ovf;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_ovf  [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  push, pop;
    logic [ATTR_WIDTH-1:0] attr_pop;
    logic                  unused_attr;

    assign unused_attr = ^attr_in;

    always_comb begin
        neg_ovf = signal_neg && (data_in == MIN_VAL);
        op      = signal_neg ? -data_in : data_in;
        if (neg_ovf && SATURATE != 0)
            op = MAX_VAL;
        sum     = signal_init ? op : acc + op;
        // overflow only when like-signed operands produce an opposite-signed result
        add_ovf = !signal_init && (acc[MSB] == op[MSB]) && (sum[MSB] != acc[MSB]);
        if (add_ovf && SATURATE != 0)
            sum = acc[MSB] ? MIN_VAL : MAX_VAL;
        acc_nxt = acc;
        ovf_nxt = ovf;
        if (signal_load) begin
            acc_nxt = sum;
            ovf_nxt = (signal_init ? 1'b0 : ovf) | attr_in[OVERFLOW] | neg_ovf | add_ovf;
        end
    end

    // a pop frees a slot in the same cycle, so a full buffer still accepts commit+pop
    assign pop       = signal_oe && (count != '0);
    assign push      = signal_commit && ((count != FULL_CNT) || pop);
    assign buf_full  = (count == FULL_CNT);
    assign buf_empty = (count == '0);

    always_comb begin
        attr_pop           = '0;
        attr_pop[SIGN]     = mem_data[rd_ptr][MSB];
        attr_pop[OVERFLOW] = mem_ovf[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            ovf      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lost     <= 1'b0;
            data_out <= '0;
            attr_out <= '0;
        end else begin
            acc      <= signal_commit ? '0 : acc_nxt;
            ovf      <= signal_commit ? 1'b0 : ovf_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (signal_commit && !push)
                lost <= 1'b1;
            data_out <= pop ? mem_data[rd_ptr] : '0;
            attr_out <= pop ? attr_pop : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= acc_nxt;
            mem_ovf[wr_ptr]  <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_pu_accum_queue.sv
// Directed and random checks of pu_accum_queue (wrap and saturate builds side by side)
// against an integer-arithmetic reference model with queue-based result buffers.
module tb_pu_accum_queue;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, load, init, neg, commit, oe;
    logic [7:0] din;
    logic [3:0] ain;
    logic [7:0] do0, do1;
    logic [3:0] ao0, ao1;
    logic       f0, e0, l0, f1, e1, l1;

    typedef struct { int d; bit o; } ent_t;
    int   acc_m [2];
    bit   ovf_m [2];
    ent_t q0[$], q1[$];
    bit   lost_m;
    int   exp_d [2];
    int   exp_a [2];
    int   passed = 0, total = 0;

    always #5 clk = ~clk;

    pu_accum_queue #(.SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .signal_load(load), .signal_init(init), .signal_neg(neg),
        .signal_commit(commit), .data_in(din), .attr_in(ain), .signal_oe(oe),
        .data_out(do0), .attr_out(ao0), .buf_full(f0), .buf_empty(e0), .lost(l0));

    pu_accum_queue #(.SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .signal_load(load), .signal_init(init), .signal_neg(neg),
        .signal_commit(commit), .data_in(din), .attr_in(ain), .signal_oe(oe),
        .data_out(do1), .attr_out(ao1), .buf_full(f1), .buf_empty(e1), .lost(l1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int wrap8(input int x);
        logic [7:0] b;
        b = x[7:0];
        return int'($signed(b));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            acc_m[s] = 0; ovf_m[s] = 0; exp_d[s] = 0; exp_a[s] = 0;
        end
        q0.delete(); q1.delete();
        lost_m = 0;
    endtask

    // Applies one rising edge of the specified behaviour to both models.
    task automatic model_clock();
        for (int s = 0; s < 2; s++) begin
            int d, opv, raw, nacc, sz;
            bit nov, aovf, novf, sat, popok;
            ent_t e;
            sat  = (s == 1);
            d    = int'($signed(din));
            nov  = neg && (d == -128);
            opv  = neg ? -d : d;
            if (nov) opv = sat ? 127 : -128;
            nacc = acc_m[s];
            novf = ovf_m[s];
            if (load) begin
                raw  = init ? opv : acc_m[s] + opv;
                aovf = !init && (raw > 127 || raw < -128);
                nacc = !aovf ? raw : (sat ? (raw > 127 ? 127 : -128) : wrap8(raw));
                novf = (init ? 1'b0 : ovf_m[s]) | ain[1] | nov | aovf;
            end
            sz       = (s == 0) ? q0.size() : q1.size();
            popok    = oe && sz > 0;
            exp_d[s] = 0;
            exp_a[s] = 0;
            if (popok) begin
                e        = (s == 0) ? q0.pop_front() : q1.pop_front();
                exp_d[s] = e.d & 255;
                exp_a[s] = (e.d < 0 ? 1 : 0) | (e.o ? 2 : 0);
            end
            if (commit) begin
                if (sz < D || popok) begin
                    e.d = nacc; e.o = novf;
                    if (s == 0) q0.push_back(e); else q1.push_back(e);
                end else if (s == 0) begin
                    lost_m = 1;
                end
                nacc = 0; novf = 0;
            end
            acc_m[s] = nacc;
            ovf_m[s] = novf;
        end
    endtask

    task automatic check_all();
        chk("dout_wrap", do0, exp_d[0]);
        chk("attr_wrap", ao0, exp_a[0]);
        chk("full_wrap", f0, q0.size() == D);
        chk("empty_wrap", e0, q0.size() == 0);
        chk("lost_wrap", l0, lost_m);
        chk("dout_sat", do1, exp_d[1]);
        chk("attr_sat", ao1, exp_a[1]);
        chk("full_sat", f1, q1.size() == D);
        chk("empty_sat", e1, q1.size() == 0);
        chk("lost_sat", l1, lost_m);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic drv(input bit ld, input bit in, input bit ng, input bit cm, input bit pe,
                       input logic [7:0] d, input logic [3:0] a);
        load = ld; init = in; neg = ng; commit = cm; oe = pe; din = d; ain = a;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        load = 0; init = 0; neg = 0; commit = 0; oe = 0; din = 0; ain = 0;
        rst = 1'b1;
        model_reset();
        #3;
        check_all();
        do_reset();

        // 5 + 3 - 2
        drv(1, 1, 0, 0, 0, 8'd5, 4'h0);
        drv(1, 0, 0, 0, 0, 8'd3, 4'h0);
        drv(1, 0, 1, 0, 0, 8'd2, 4'h0);
        drv(0, 0, 0, 1, 0, 8'd0, 4'h0);
        drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
        chk("sum6_dout", do0, 6);
        chk("sum6_attr", ao0, 0);

        // 100 + 100 with commit on the adding load
        drv(1, 1, 0, 0, 0, 8'd100, 4'h0);
        drv(1, 0, 0, 1, 0, 8'd100, 4'h0);
        drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
        chk("ovf_wrap_dout", do0, 8'hC8);
        chk("ovf_wrap_attr", ao0, 3);
        chk("ovf_sat_dout", do1, 8'h7F);
        chk("ovf_sat_attr", ao1, 2);

        // fill, drop, drain, pop empty
        for (int i = 1; i <= 4; i++) drv(1, 1, 0, 1, 0, 8'(i), 4'h0);
        chk("fill_full", f0, 1);
        drv(1, 1, 0, 1, 0, 8'd5, 4'h0);
        chk("drop_lost", l0, 1);
        for (int i = 1; i <= 4; i++) begin
            drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
            chk("drain_order", do0, i);
        end
        chk("drain_empty", e0, 1);
        drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
        chk("pop_empty_dout", do0, 0);
        do_reset();

        // commit and pop together while full
        for (int i = 1; i <= 4; i++) drv(1, 1, 0, 1, 0, 8'(i), 4'h0);
        drv(1, 1, 0, 1, 1, 8'd9, 4'h0);
        chk("fullpop_dout", do0, 1);
        chk("fullpop_full", f0, 1);
        chk("fullpop_lost", l0, 0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
            chk("fullpop_order", do0, (i == 3) ? 9 : i + 2);
        end

        // negate of most-negative value, and attribute overflow on a non-init load
        drv(1, 1, 1, 0, 0, 8'h80, 4'h0);
        drv(0, 0, 0, 1, 0, 8'd0, 4'h0);
        drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
        chk("negmin_ovf_wrap", ao0[1], 1);
        chk("negmin_ovf_sat", ao1[1], 1);
        chk("negmin_sat_dout", do1, 8'h7F);
        drv(1, 1, 0, 0, 0, 8'd3, 4'h0);
        drv(1, 0, 0, 1, 0, 8'd1, 4'b0010);
        drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
        chk("attr_ovf_in", ao0, 2);
        chk("attr_ovf_dout", do0, 4);

        // asynchronous reset between edges with two entries held
        drv(1, 1, 0, 1, 0, 8'd11, 4'h0);
        drv(1, 1, 0, 1, 1, 8'd12, 4'h0);
        drv(1, 1, 0, 0, 0, 8'd20, 4'h0);
        load = 0; init = 0; commit = 0; oe = 0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_empty", e0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drv(1, 1, 0, 1, 0, 8'd7, 4'h0);
        drv(0, 0, 0, 0, 1, 8'd0, 4'h0);
        chk("post_rst_dout", do0, 7);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 4) == 0), d,
                ($urandom_range(0, 15) == 0) ? 4'b0010 : 4'($urandom) & 4'b1101);
            if (n == 300) do_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
